spart_ctrl: RTL and testbench

SPART_CTRL -- requirements
Module: spart_ctrl

---
 rtl/spart_pkg.sv | 43 ++++
 rtl/spart_ctrl.sv | 149 ++++++++++++++
 tb/tb_spart_ctrl.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/spart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spart_pkg
//  Description : Shared types, SPART register addresses and the baud-select
//                to divisor table used by the SPART bus controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package spart_pkg;

    typedef enum logic [2:0] {
        START  = 3'd0,
        CFG_LO = 3'd1,
        CFG_HI = 3'd2,
        POLL   = 3'd3,
        READ   = 3'd4,
        WRITE  = 3'd5
    } spart_state_t;

    localparam logic [1:0] DATA    = 2'b00;
    localparam logic [1:0] STATUS  = 2'b01;
    localparam logic [1:0] DB_LOW  = 2'b10;
    localparam logic [1:0] DB_HIGH = 2'b11;

    // 50 MHz clock, 16x oversampling
    localparam logic [15:0] DIV_4800  = 16'd651;
    localparam logic [15:0] DIV_9600  = 16'd326;
    localparam logic [15:0] DIV_19200 = 16'd163;
    localparam logic [15:0] DIV_38400 = 16'd81;

    function automatic logic [15:0] baud_divisor(input logic [1:0] sel);
        logic [15:0] div;
        div = DIV_4800;
        case (sel)
            2'b00:   div = DIV_4800;
            2'b01:   div = DIV_9600;
            2'b10:   div = DIV_19200;
            default: div = DIV_38400;
        endcase
        return div;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spart_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : spart_ctrl
//  Description : Bus master for a SPART: programs the baud divisor, then polls
//                STATUS and moves bytes between the SPART and tx/rx handshakes.
//  Revision    : 1.0 - initial release
// ============================================================================
module spart_ctrl
    import spart_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] br_cfg,
    output logic       iocs,
    output logic       iorw,
    output logic [1:0] ioaddr,
    inout  wire  [7:0] databus,
    input  logic       tx_valid,
    input  logic [7:0] tx_byte,
    output logic       tx_ready,
    output logic       rx_valid,
    output logic [7:0] rx_byte,
    input  logic       rx_ready,
    output logic       cfg_done
);

    spart_state_t r_state;
    spart_state_t w_next_state;

    logic [1:0]  r_br_cfg_q;
    logic        r_last_rx;
    logic        r_rx_valid;
    logic [7:0]  r_rx_byte;

    logic [7:0]  w_wdata;
    logic [15:0] w_div;
    logic        w_rx_want;
    logic        w_tx_want;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= START;
        end else begin
            r_state <= w_next_state;
        end
    end

    assign w_rx_want = databus[0] && !r_rx_valid;
    assign w_tx_want = databus[1] && tx_valid;

    // Bus outputs are decoded from the state so reset clears them immediately
    always_comb begin
        w_next_state = r_state;
        iocs         = 1'b1;
        iorw         = 1'b1;
        ioaddr       = STATUS;
        tx_ready     = 1'b0;
        cfg_done     = 1'b1;
        w_wdata      = 8'h00;
        w_div        = 16'h0000;

        case (r_state)
            START: begin
                iocs         = 1'b0;
                ioaddr       = DATA;
                cfg_done     = 1'b0;
                w_next_state = CFG_LO;
            end
            CFG_LO: begin
                iorw         = 1'b0;
                ioaddr       = DB_LOW;
                cfg_done     = 1'b0;
                w_div        = baud_divisor(br_cfg);
                w_wdata      = w_div[7:0];
                w_next_state = CFG_HI;
            end
            CFG_HI: begin
                iorw         = 1'b0;
                ioaddr       = DB_HIGH;
                cfg_done     = 1'b0;
                w_div        = baud_divisor(r_br_cfg_q);
                w_wdata      = w_div[15:8];
                w_next_state = POLL;
            end
            POLL: begin
                ioaddr = STATUS;
                if (br_cfg != r_br_cfg_q) begin
                    w_next_state = CFG_LO;
                end else if (w_rx_want && w_tx_want) begin
                    w_next_state = r_last_rx ? WRITE : READ;
                end else if (w_rx_want) begin
                    w_next_state = READ;
                end else if (w_tx_want) begin
                    w_next_state = WRITE;
                end else begin
                    w_next_state = POLL;
                end
            end
            READ: begin
                ioaddr       = DATA;
                w_next_state = POLL;
            end
            WRITE: begin
                iorw         = 1'b0;
                ioaddr       = DATA;
                w_wdata      = tx_byte;
                tx_ready     = 1'b1;
                w_next_state = POLL;
            end
            default: begin
                iocs         = 1'b0;
                ioaddr       = DATA;
                cfg_done     = 1'b0;
                w_next_state = START;
            end
        endcase
    end

    // Low divisor byte is taken from live br_cfg, so latch it while CFG_LO drives it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_br_cfg_q <= 2'b00;
            r_last_rx  <= 1'b0;
            r_rx_valid <= 1'b0;
            r_rx_byte  <= 8'h00;
        end else begin
            if (r_state == CFG_LO) begin
                r_br_cfg_q <= br_cfg;
            end
            if (w_next_state == READ) begin
                r_last_rx <= 1'b1;
            end else if (w_next_state == WRITE) begin
                r_last_rx <= 1'b0;
            end
            if (r_state == READ) begin
                r_rx_byte  <= databus;
                r_rx_valid <= 1'b1;
            end else if (r_rx_valid && rx_ready) begin
                r_rx_valid <= 1'b0;
            end
        end
    end

    assign rx_valid = r_rx_valid;
    assign rx_byte  = r_rx_byte;
    assign databus  = (iocs && !iorw) ? w_wdata : 8'bzzzz_zzzz;

endmodule
`default_nettype wire

// File: tb/tb_spart_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spart_ctrl
//  Description : Directed self-checking bench for spart_ctrl with a small
//                SPART register model answering bus reads.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spart_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] br_cfg = 2'b01;
    logic       iocs;
    logic       iorw;
    logic [1:0] ioaddr;
    wire  [7:0] databus;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_byte = 8'h00;
    logic       tx_ready;
    logic       rx_valid;
    logic [7:0] rx_byte;
    logic       rx_ready = 1'b0;
    logic       cfg_done;

    logic [7:0] status_val = 8'h00;
    logic [7:0] rx_data = 8'h00;

    int checks = 0;
    int errors = 0;

    // Expected {iocs, iorw, ioaddr} per access type
    localparam logic [3:0] B_READ  = 4'b1100;
    localparam logic [3:0] B_POLL  = 4'b1101;
    localparam logic [3:0] B_WRITE = 4'b1000;
    localparam logic [3:0] B_CLO   = 4'b1010;
    localparam logic [3:0] B_CHI   = 4'b1011;

    always #5 clk = ~clk;

    assign databus = (iocs && iorw) ? ((ioaddr == 2'b01) ? status_val : rx_data) : 8'bzzzz_zzzz;

    spart_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .br_cfg   (br_cfg),
        .iocs     (iocs),
        .iorw     (iorw),
        .ioaddr   (ioaddr),
        .databus  (databus),
        .tx_valid (tx_valid),
        .tx_byte  (tx_byte),
        .tx_ready (tx_ready),
        .rx_valid (rx_valid),
        .rx_byte  (rx_byte),
        .rx_ready (rx_ready),
        .cfg_done (cfg_done)
    );

    task automatic test_reset();
        rst = 1'b0;
        br_cfg = 2'b01;
        repeat (2) @(negedge clk);
        checks++; if ({iocs, iorw, ioaddr} !== 4'b0100) begin errors++; $display("FAIL reset_bus got %b exp 0100", {iocs, iorw, ioaddr}); end
        checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL reset_tx_ready got %b exp 0", tx_ready); end
        checks++; if (rx_valid !== 1'b0 || rx_byte !== 8'h00) begin errors++; $display("FAIL reset_rx got %b/%h exp 0/00", rx_valid, rx_byte); end
        checks++; if (cfg_done !== 1'b0) begin errors++; $display("FAIL reset_cfg_done got %b exp 0", cfg_done); end
        rst = 1'b1;
    endtask

    task automatic test_config();
        logic [3:0] eb [3];
        logic [7:0] ed [3];
        logic       ec [3];
        eb = '{B_CLO, B_CHI, B_POLL};
        ed = '{8'h46, 8'h01, 8'h00};
        ec = '{1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if ({iocs, iorw, ioaddr} !== eb[i]) begin errors++; $display("FAIL cfg_bus[%0d] got %b exp %b", i, {iocs, iorw, ioaddr}, eb[i]); end
            if (i < 2) begin
                checks++; if (databus !== ed[i]) begin errors++; $display("FAIL cfg_data[%0d] got %h exp %h", i, databus, ed[i]); end
            end
            checks++; if (cfg_done !== ec[i]) begin errors++; $display("FAIL cfg_done[%0d] got %b exp %b", i, cfg_done, ec[i]); end
        end
    endtask

    task automatic test_read();
        status_val = 8'h01; rx_data = 8'hBE; rx_ready = 1'b0;
        @(negedge clk);
        checks++; if ({iocs, iorw, ioaddr} !== B_READ) begin errors++; $display("FAIL read_bus got %b exp %b", {iocs, iorw, ioaddr}, B_READ); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL read_rx_valid_early got %b exp 0", rx_valid); end
        @(negedge clk);
        checks++; if (rx_valid !== 1'b1 || rx_byte !== 8'hBE) begin errors++; $display("FAIL read_capture got %b/%h exp 1/be", rx_valid, rx_byte); end
        for (int i = 0; i < 4; i++) begin
            checks++; if ({iocs, iorw, ioaddr} !== B_POLL) begin errors++; $display("FAIL read_hold[%0d] got %b exp %b", i, {iocs, iorw, ioaddr}, B_POLL); end
            if (i < 3) @(negedge clk);
        end
        rx_ready = 1'b1;
        @(negedge clk);
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL read_consume got %b exp 0", rx_valid); end
        checks++; if ({iocs, iorw, ioaddr} !== B_POLL) begin errors++; $display("FAIL read_no_reread got %b exp %b", {iocs, iorw, ioaddr}, B_POLL); end
        rx_ready = 1'b0; status_val = 8'h00;
        @(negedge clk);
    endtask

    task automatic test_write();
        status_val = 8'h02; tx_valid = 1'b1; tx_byte = 8'h12;
        @(negedge clk);
        checks++; if ({iocs, iorw, ioaddr} !== B_WRITE) begin errors++; $display("FAIL write_bus got %b exp %b", {iocs, iorw, ioaddr}, B_WRITE); end
        checks++; if (databus !== 8'h12) begin errors++; $display("FAIL write_data got %h exp 12", databus); end
        checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL write_tx_ready got %b exp 1", tx_ready); end
        tx_valid = 1'b0; status_val = 8'h00;
        @(negedge clk);
        checks++; if (tx_ready !== 1'b0 || {iocs, iorw, ioaddr} !== B_POLL) begin errors++; $display("FAIL write_after got %b/%b exp 0/%b", tx_ready, {iocs, iorw, ioaddr}, B_POLL); end
    endtask

    task automatic test_alternate();
        logic [3:0] eb [8];
        eb = '{B_READ, B_POLL, B_WRITE, B_POLL, B_READ, B_POLL, B_WRITE, B_POLL};
        status_val = 8'h03; tx_valid = 1'b1; tx_byte = 8'h5A; rx_data = 8'hC3; rx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++; if ({iocs, iorw, ioaddr} !== eb[i]) begin errors++; $display("FAIL alt_bus[%0d] got %b exp %b", i, {iocs, iorw, ioaddr}, eb[i]); end
        end
        status_val = 8'h00; tx_valid = 1'b0;
        checks++; if (rx_byte !== 8'hC3) begin errors++; $display("FAIL alt_rx_byte got %h exp c3", rx_byte); end
    endtask

    task automatic test_round_robin();
        status_val = 8'h01; tx_valid = 1'b0; rx_ready = 1'b1;
        @(negedge clk);
        checks++; if ({iocs, iorw, ioaddr} !== B_READ) begin errors++; $display("FAIL rr_read got %b exp %b", {iocs, iorw, ioaddr}, B_READ); end
        status_val = 8'h00;
        repeat (2) @(negedge clk);
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL rr_rx_empty got %b exp 0", rx_valid); end
        status_val = 8'h03; tx_valid = 1'b1; tx_byte = 8'h3C;
        @(negedge clk);
        checks++; if ({iocs, iorw, ioaddr} !== B_WRITE || databus !== 8'h3C) begin errors++; $display("FAIL rr_write got %b/%h exp %b/3c", {iocs, iorw, ioaddr}, databus, B_WRITE); end
        status_val = 8'h00; tx_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reconfig_during_write();
        logic [3:0] eb [4];
        logic [7:0] ed [4];
        logic       ec [4];
        eb = '{B_POLL, B_CLO, B_CHI, B_POLL};
        ed = '{8'h00, 8'h51, 8'h00, 8'h00};
        ec = '{1'b1, 1'b0, 1'b0, 1'b1};
        status_val = 8'h02; tx_valid = 1'b1; tx_byte = 8'h77; rx_ready = 1'b0;
        @(negedge clk);
        checks++; if ({iocs, iorw, ioaddr} !== B_WRITE || databus !== 8'h77) begin errors++; $display("FAIL rcfg_write got %b/%h exp %b/77", {iocs, iorw, ioaddr}, databus, B_WRITE); end
        br_cfg = 2'b11; tx_valid = 1'b0; status_val = 8'h00;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if ({iocs, iorw, ioaddr} !== eb[i]) begin errors++; $display("FAIL rcfg_bus[%0d] got %b exp %b", i, {iocs, iorw, ioaddr}, eb[i]); end
            if (i == 1 || i == 2) begin
                checks++; if (databus !== ed[i]) begin errors++; $display("FAIL rcfg_data[%0d] got %h exp %h", i, databus, ed[i]); end
            end
            checks++; if (cfg_done !== ec[i]) begin errors++; $display("FAIL rcfg_done[%0d] got %b exp %b", i, cfg_done, ec[i]); end
        end
    endtask

    task automatic test_divisors();
        logic [1:0] cfg [3];
        logic [7:0] lo [3];
        logic [7:0] hi [3];
        cfg = '{2'b00, 2'b10, 2'b01};
        lo  = '{8'h8B, 8'hA3, 8'h46};
        hi  = '{8'h02, 8'h00, 8'h01};
        for (int i = 0; i < 3; i++) begin
            br_cfg = cfg[i];
            @(negedge clk);
            checks++; if ({iocs, iorw, ioaddr} !== B_CLO || databus !== lo[i]) begin errors++; $display("FAIL div_lo[%0d] got %b/%h exp %b/%h", i, {iocs, iorw, ioaddr}, databus, B_CLO, lo[i]); end
            @(negedge clk);
            checks++; if ({iocs, iorw, ioaddr} !== B_CHI || databus !== hi[i]) begin errors++; $display("FAIL div_hi[%0d] got %b/%h exp %b/%h", i, {iocs, iorw, ioaddr}, databus, B_CHI, hi[i]); end
            @(negedge clk);
            checks++; if ({iocs, iorw, ioaddr} !== B_POLL || cfg_done !== 1'b1) begin errors++; $display("FAIL div_poll[%0d] got %b/%b exp %b/1", i, {iocs, iorw, ioaddr}, cfg_done, B_POLL); end
        end
    endtask

    task automatic test_reset_mid_write();
        status_val = 8'h01; rx_data = 8'hAA; rx_ready = 1'b0; tx_valid = 1'b0;
        @(negedge clk);
        status_val = 8'h03; tx_valid = 1'b1; tx_byte = 8'h99;
        @(negedge clk);
        checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL rmw_rx_valid got %b exp 1", rx_valid); end
        @(negedge clk);
        checks++; if ({iocs, iorw, ioaddr} !== B_WRITE || tx_ready !== 1'b1) begin errors++; $display("FAIL rmw_write got %b/%b exp %b/1", {iocs, iorw, ioaddr}, tx_ready, B_WRITE); end
        #2 rst = 1'b0;
        #1;
        checks++; if ({iocs, iorw, ioaddr} !== 4'b0100) begin errors++; $display("FAIL rmw_abort_bus got %b exp 0100", {iocs, iorw, ioaddr}); end
        checks++; if (tx_ready !== 1'b0 || rx_valid !== 1'b0 || rx_byte !== 8'h00 || cfg_done !== 1'b0) begin errors++; $display("FAIL rmw_abort_out got %b/%b/%h/%b exp 0/0/00/0", tx_ready, rx_valid, rx_byte, cfg_done); end
        tx_valid = 1'b0; status_val = 8'h00;
        @(negedge clk);
        checks++; if (iocs !== 1'b0) begin errors++; $display("FAIL rmw_held got %b exp 0", iocs); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if ({iocs, iorw, ioaddr} !== B_CLO || databus !== 8'h46) begin errors++; $display("FAIL rmw_cfg_lo got %b/%h exp %b/46", {iocs, iorw, ioaddr}, databus, B_CLO); end
        @(negedge clk);
        checks++; if ({iocs, iorw, ioaddr} !== B_CHI || databus !== 8'h01) begin errors++; $display("FAIL rmw_cfg_hi got %b/%h exp %b/01", {iocs, iorw, ioaddr}, databus, B_CHI); end
        @(negedge clk);
        checks++; if ({iocs, iorw, ioaddr} !== B_POLL || cfg_done !== 1'b1) begin errors++; $display("FAIL rmw_poll got %b/%b exp %b/1", {iocs, iorw, ioaddr}, cfg_done, B_POLL); end
    endtask

    initial begin
        test_reset();
        test_config();
        test_read();
        test_write();
        test_alternate();
        test_round_robin();
        test_reconfig_during_write();
        test_divisors();
        test_reset_mid_write();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
